// File: rtl/sdr_host_resp_if.sv
// Host-side SDRAM controller bus: address/strobe/data from the host master, status and read data back.
// sys_ERR exists only when SDR_RESP_ERR_EN is defined.
interface sdr_host_resp_if;
  logic [23:1] sys_A;
  logic        sys_ADSn;
  logic        sys_R_Wn;
  logic [15:0] sys_D;
  logic        sys_REF_REQ;
  logic        sys_DLY_100US;
  logic        sys_INIT_DONE;
  logic        sys_CYC_END;
  logic [15:0] sys_RD_D;
  logic        sys_RD_VALID;
`ifdef SDR_RESP_ERR_EN
  logic        sys_ERR;
`endif

  modport master (
`ifdef SDR_RESP_ERR_EN
    input  sys_ERR,
`endif
    output sys_A, sys_ADSn, sys_R_Wn, sys_D, sys_REF_REQ, sys_DLY_100US,
    input  sys_INIT_DONE, sys_CYC_END, sys_RD_D, sys_RD_VALID
  );

  modport slave (
`ifdef SDR_RESP_ERR_EN
    output sys_ERR,
`endif
    input  sys_A, sys_ADSn, sys_R_Wn, sys_D, sys_REF_REQ, sys_DLY_100US,
    output sys_INIT_DONE, sys_CYC_END, sys_RD_D, sys_RD_VALID
  );
endinterface

// File: rtl/sdr_host_resp.sv
// Host-bus target emulating SDRAM controller timing: 8-beat wrapping bursts, first read beat RD_LAT after ADSn.
// No backpressure; ADSn outside IDLE is dropped (flagged on sys_ERR when SDR_RESP_ERR_EN is defined).
module sdr_host_resp #(
  parameter int INIT_CYCLES = 200,
  parameter int RD_LAT      = 2,
  parameter int REF_CYCLES  = 6,
  parameter int TAG_W       = 2
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  sdr_host_resp_if.slave bus
);
  localparam int CNT_W = 16;
  localparam int IDX_W = TAG_W + 3;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);
  localparam logic [CNT_W-1:0] REF_LAST  = CNT_W'(REF_CYCLES - 1);

  typedef enum logic [2:0] {INIT, IDLE, WR_BURST, RD_WAIT, RD_BURST, REFRESH} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       beat, beat_nxt;
  logic [TAG_W-1:0] tag, tag_nxt;
  logic [2:0]       base_lo, base_lo_nxt;
  logic             dly_lat, init_done, ref_pend, rd_valid;
  logic [15:0]      rd_d;
  logic [15:0]      mem [DEPTH];
  logic             ads, last_beat;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             unused_addr;

  assign ads         = ~bus.sys_ADSn;
  assign last_beat   = (beat == 3'd7);
  assign unused_addr = ^bus.sys_A;
  // Beat offset wraps inside the aligned 8-word block selected by the tag.
  assign wr_idx = {tag, 3'(base_lo + beat)};
  assign rd_idx = {tag_nxt, 3'(base_lo_nxt + beat_nxt)};

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    beat_nxt    = beat;
    tag_nxt     = tag;
    base_lo_nxt = base_lo;
    case (state)
      INIT: begin
        if (dly_lat) begin
          if (cnt == INIT_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      IDLE: begin
        cnt_nxt  = '0;
        beat_nxt = '0;
        if (ads) begin
          tag_nxt     = bus.sys_A[10+TAG_W-1:10];
          base_lo_nxt = bus.sys_A[3:1];
          if (!bus.sys_R_Wn)  state_nxt = WR_BURST;
          else if (RD_LAT > 1) state_nxt = RD_WAIT;
          else                 state_nxt = RD_BURST;
        end else if (bus.sys_REF_REQ || ref_pend) begin
          state_nxt = REFRESH;
        end
      end
      WR_BURST, RD_BURST: begin
        beat_nxt = beat + 3'd1;
        if (last_beat) state_nxt = IDLE;
      end
      RD_WAIT: begin
        if (cnt == WAIT_LAST) begin
          state_nxt = RD_BURST;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      REFRESH: begin
        if (cnt == REF_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= INIT;
      cnt     <= '0;
      beat    <= '0;
      tag     <= '0;
      base_lo <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      beat    <= beat_nxt;
      tag     <= tag_nxt;
      base_lo <= base_lo_nxt;
    end
  end

  // An ADSn cycle in IDLE defers refresh; any other cycle in IDLE either refreshes or has nothing pending.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dly_lat   <= 1'b0;
      init_done <= 1'b0;
      ref_pend  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_d      <= '0;
    end else begin
      dly_lat   <= dly_lat | bus.sys_DLY_100US;
      init_done <= init_done | (state == INIT && state_nxt == IDLE);
      if (state == IDLE && !ads) ref_pend <= 1'b0;
      else if (bus.sys_REF_REQ)  ref_pend <= 1'b1;
      rd_valid <= (state_nxt == RD_BURST);
      rd_d     <= (state_nxt == RD_BURST) ? mem[rd_idx] : '0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == WR_BURST) begin
      mem[wr_idx] <= bus.sys_D;
    end
  end

`ifdef SDR_RESP_ERR_EN
  logic err;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) err <= 1'b0;
    else            err <= err | (ads && state != IDLE);
  end
  assign bus.sys_ERR = err;
`endif

  assign bus.sys_INIT_DONE = init_done;
  assign bus.sys_CYC_END   = (state == WR_BURST || state == RD_BURST) && last_beat;
  assign bus.sys_RD_D      = rd_d;
  assign bus.sys_RD_VALID  = rd_valid;
endmodule

// File: tb/tb_sdr_host_resp.sv
// Directed + randomized bench for sdr_host_resp; burst data checked against a flat-array memory model.
module tb_sdr_host_resp;
  localparam int INIT_CYCLES = 200;
  localparam int RD_LAT      = 2;
  localparam int REF_CYCLES  = 6;
  localparam int TAG_W       = 2;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  int   n_chk     = 0;
  int   n_fail    = 0;
  logic [15:0] mdl [32];

  sdr_host_resp_if bus ();

  sdr_host_resp #(
    .INIT_CYCLES(INIT_CYCLES), .RD_LAT(RD_LAT), .REF_CYCLES(REF_CYCLES), .TAG_W(TAG_W)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word slot a burst beat lands in: tag selects the 8-word block, the low index wraps mod 8.
  function automatic int midx(input logic [23:1] a, input int k);
    return int'(a[11:10]) * 8 + (int'(a[3:1]) + k) % 8;
  endfunction

  task automatic do_write(input logic [23:1] a, input logic [7:0][15:0] d, input bit glitch);
    bus.sys_ADSn = 1'b0; bus.sys_R_Wn = 1'b0; bus.sys_A = a;
    tick();
    for (int b = 0; b < 8; b++) begin
      bus.sys_ADSn = (glitch && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      bus.sys_R_Wn = 1'($urandom);
      bus.sys_A    = 23'($urandom);
      bus.sys_D    = d[b];
      mdl[midx(a, b)] = d[b];
      check("wr_cyc_end", bus.sys_CYC_END, (b == 7));
      check("wr_rd_valid", bus.sys_RD_VALID, 0);
      tick();
    end
    bus.sys_ADSn = 1'b1;
  endtask

  task automatic do_read(input logic [23:1] a, input bit with_ref, input bit glitch);
    bus.sys_ADSn = 1'b0; bus.sys_R_Wn = 1'b1; bus.sys_A = a; bus.sys_REF_REQ = with_ref;
    tick();
    bus.sys_REF_REQ = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      bus.sys_ADSn = (glitch && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      bus.sys_R_Wn = 1'($urandom);
      bus.sys_D    = 16'($urandom);
      check("rd_valid", bus.sys_RD_VALID, (c >= RD_LAT));
      if (c >= RD_LAT) check("rd_data", bus.sys_RD_D, mdl[midx(a, c - RD_LAT)]);
      check("rd_cyc_end", bus.sys_CYC_END, (c == RD_LAT + 7));
      tick();
    end
    bus.sys_ADSn = 1'b1;
  endtask

  initial begin
    logic [7:0][15:0] d;
    logic [23:1]      a;
    logic [15:0]      pat [4];

    for (int i = 0; i < 32; i++) mdl[i] = '0;
    bus.sys_A = '0; bus.sys_ADSn = 1'b1; bus.sys_R_Wn = 1'b1; bus.sys_D = '0;
    bus.sys_REF_REQ = 1'b0; bus.sys_DLY_100US = 1'b0;
    repeat (3) tick();
    check("rst_init_done", bus.sys_INIT_DONE, 0);
    check("rst_cyc_end", bus.sys_CYC_END, 0);
    check("rst_rd_valid", bus.sys_RD_VALID, 0);
    check("rst_rd_d", bus.sys_RD_D, 0);
    sys_rst_n = 1'b1;

    // Until init completes, ADSn is ignored.
    for (int n = 0; n < 299; n++) begin
      bus.sys_ADSn = (n % 37 == 5) ? 1'b0 : 1'b1;
      bus.sys_R_Wn = n[0];
      check("pre_init_quiet", {bus.sys_CYC_END, bus.sys_RD_VALID}, 0);
      tick();
    end
    bus.sys_ADSn = 1'b1;
`ifdef SDR_RESP_ERR_EN
    check("err_pre_init", bus.sys_ERR, 1);
`endif
    bus.sys_DLY_100US = 1'b1;
    tick();
    bus.sys_DLY_100US = 1'b0;
    for (int n = 1; n <= INIT_CYCLES; n++) begin
      tick();
      check("init_done_timing", bus.sys_INIT_DONE, (n == INIT_CYCLES));
    end

    for (int b = 0; b < 8; b++) d[b] = 16'h1234;
    do_write(23'd0, d, 1'b0);
    do_read(23'd0, 1'b0, 1'b0);

    pat[0] = 16'h1234; pat[1] = 16'h5678; pat[2] = 16'h9abc; pat[3] = 16'hdef0;
    for (int t = 0; t < 4; t++) begin
      for (int b = 0; b < 8; b++) d[b] = pat[t];
      do_write(23'(512 * t), d, 1'b0);
    end
    for (int t = 0; t < 4; t++) begin
      do_read(23'(512 * t), 1'b0, 1'b0);
      tick();
    end

    for (int b = 0; b < 8; b++) d[b] = 16'(b);
    do_write(23'd5, d, 1'b0);
    do_read(23'd0, 1'b0, 1'b0);

    for (int it = 0; it < 24; it++) begin
      a = 23'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        for (int b = 0; b < 8; b++) d[b] = 16'($urandom);
        do_write(a, d, 1'b1);
      end else begin
        do_read(a, 1'b0, 1'b1);
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    // Reset in the middle of a write burst.
    for (int b = 0; b < 8; b++) d[b] = 16'hbeef;
    bus.sys_ADSn = 1'b0; bus.sys_R_Wn = 1'b0; bus.sys_A = 23'd0;
    tick();
    bus.sys_ADSn = 1'b1;
    for (int b = 0; b < 4; b++) begin
      bus.sys_D = d[b];
      tick();
    end
    sys_rst_n = 1'b0;
    #1;
    check("abort_init_done", bus.sys_INIT_DONE, 0);
    check("abort_cyc_end", bus.sys_CYC_END, 0);
    check("abort_rd_valid", bus.sys_RD_VALID, 0);
    check("abort_rd_d", bus.sys_RD_D, 0);
`ifdef SDR_RESP_ERR_EN
    check("abort_err", bus.sys_ERR, 0);
`endif
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    repeat (2) tick();
    sys_rst_n = 1'b1;
    for (int n = 0; n < 12; n++) begin
      check("abort_no_cyc_end", bus.sys_CYC_END, 0);
      tick();
    end
    bus.sys_DLY_100US = 1'b1;
    tick();
    bus.sys_DLY_100US = 1'b0;
    repeat (INIT_CYCLES - 1) tick();
    check("reinit_early", bus.sys_INIT_DONE, 0);
    tick();
    check("reinit_done", bus.sys_INIT_DONE, 1);
`ifdef SDR_RESP_ERR_EN
    check("reinit_err", bus.sys_ERR, 0);
`endif
    do_read(23'd0, 1'b0, 1'b0);
    do_read(23'd1536, 1'b0, 1'b0);

    // Refresh deferred past a read; an ADSn in its last cycle is dropped, the next cycle is accepted.
    for (int b = 0; b < 8; b++) d[b] = 16'h0a00 + 16'(b);
    do_write(23'd1536, d, 1'b0);
    do_read(23'd1536, 1'b1, 1'b0);
    repeat (REF_CYCLES) tick();
    bus.sys_ADSn = 1'b0; bus.sys_R_Wn = 1'b0; bus.sys_A = 23'd1539; bus.sys_D = 16'hdead;
    tick();
`ifdef SDR_RESP_ERR_EN
    check("refresh_err", bus.sys_ERR, 1);
`endif
    for (int b = 0; b < 8; b++) d[b] = 16'h0c00 + 16'(b);
    do_write(23'd1536, d, 1'b0);
    do_read(23'd1536, 1'b0, 1'b0);
    do_read(23'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
